uart_buffered: RTL and testbench

//   Parametrised UART: 16x-oversampled receiver, FIFO-buffered transmitter, valid/ready byte interface.

---
 rtl/uart_buffered.sv | 365 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_buffered.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_buffered.sv
`default_nettype none
// ============================================================================
// uart_buffered : 16x-oversampled UART RX, FIFO-buffered TX, optional echo.
// Optional even parity on both directions when UART_PARITY_EN is defined.
// Revision : 1.0
// ============================================================================
module uart_buffered #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          RsRx,
  output logic                          RsTx,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  input  logic                          echo_en,
  output logic                          echo_drop,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic                          tx_busy
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TICK_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  // --------------------------------------------------------------------------
  // Oversampling tick, shared by both directions
  // --------------------------------------------------------------------------
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  assign w_tick = (r_tick_cnt == TICK_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // RX synchroniser and edge history
  // --------------------------------------------------------------------------
  logic r_rx_s1;
  logic r_rx_s2;
  logic r_rx_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= RsRx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // --------------------------------------------------------------------------
  // RX FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  rx_state_t         r_rx_state;
  rx_state_t         w_rx_next;
  logic [3:0]        r_rx_cnt;
  logic [3:0]        r_rx_bit;
  logic [DATA_W-1:0] r_rx_shift;
  logic              w_rx_sample;
  logic              w_rx_good;
  logic              w_rx_bad;
`ifdef UART_PARITY_EN
  logic              r_rx_par_bad;
  logic              r_rx_perr;
`endif

  always_comb begin
    w_rx_next   = r_rx_state;
    w_rx_good   = 1'b0;
    w_rx_bad    = 1'b0;
    // START samples at mid-bit (8 ticks); every later bit one full period on
    w_rx_sample = w_tick && (r_rx_cnt == ((r_rx_state == RX_START) ? 4'd7 : 4'd15));
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_s2) begin
          w_rx_next = RX_START;
        end
      end
      RX_START: begin
        if (w_rx_sample) begin
          w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_rx_sample && (r_rx_bit == LAST_BIT)) begin
`ifdef UART_PARITY_EN
          w_rx_next = RX_PARITY;
`else
          w_rx_next = RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (w_rx_sample) begin
          w_rx_next = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (w_rx_sample) begin
          if (r_rx_s2) begin
            w_rx_good = 1'b1;
            w_rx_next = RX_IDLE;
          end else begin
            w_rx_bad  = 1'b1;
            w_rx_next = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        if (r_rx_s2) begin
          w_rx_next = RX_IDLE;
        end
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par_bad <= 1'b0;
      r_rx_perr    <= 1'b0;
`endif
    end else begin
      r_rx_state   <= w_rx_next;
      rx_valid     <= w_rx_good;
      rx_frame_err <= w_rx_bad;
      if (w_rx_good) begin
        rx_data <= r_rx_shift;
      end
      if ((r_rx_state == RX_DATA) && w_rx_sample) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_W-1:1]};
        r_rx_bit   <= r_rx_bit + 4'd1;
      end
`ifdef UART_PARITY_EN
      if ((r_rx_state == RX_PARITY) && w_rx_sample) begin
        r_rx_par_bad <= (r_rx_s2 != ^r_rx_shift);
      end
      r_rx_perr <= w_rx_good && r_rx_par_bad;
`endif
      // Every state entry restarts the bit timer and bit index
      if (w_rx_next != r_rx_state) begin
        r_rx_cnt <= '0;
        r_rx_bit <= '0;
      end else if (w_tick) begin
        r_rx_cnt <= r_rx_cnt + 4'd1;
      end
    end
  end

`ifdef UART_PARITY_EN
  assign rx_parity_err = r_rx_perr;
`else
  assign rx_parity_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // TX FIFO; echo traffic wins over the user port
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_full;
  logic              w_empty;
  logic              w_echo_req;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_push_data;
  logic [DATA_W-1:0] w_head;

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_echo_req  = echo_en && rx_valid;
  assign tx_ready    = !w_full && !w_echo_req;
  assign w_push      = (w_echo_req && !w_full) || (tx_valid && tx_ready);
  assign w_push_data = w_echo_req ? rx_data : tx_data;
  assign echo_drop   = w_echo_req && w_full;
  assign w_head      = r_mem[r_rd_ptr];
  assign tx_count    = r_count;

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // TX FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  tx_state_t         r_tx_state;
  tx_state_t         w_tx_next;
  logic [3:0]        r_tx_cnt;
  logic [3:0]        r_tx_bit;
  logic [DATA_W-1:0] r_tx_shift;
  logic              r_tx_line;
  logic              w_tx_line;
  logic              w_tx_bit_end;
`ifdef UART_PARITY_EN
  logic              r_tx_par;
`endif

  assign w_tx_bit_end = w_tick && (r_tx_cnt == 4'd15);

  always_comb begin
    w_tx_next = r_tx_state;
    w_pop     = 1'b0;
    w_tx_line = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_tx_next = TX_START;
        end
      end
      TX_START: begin
        w_tx_line = 1'b0;
        if (w_tx_bit_end) begin
          w_tx_next = TX_DATA;
        end
      end
      TX_DATA: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_bit_end && (r_tx_bit == LAST_BIT)) begin
`ifdef UART_PARITY_EN
          w_tx_next = TX_PARITY;
`else
          w_tx_next = TX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        w_tx_line = r_tx_par;
        if (w_tx_bit_end) begin
          w_tx_next = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        // Chain straight into the next start bit when more data is queued
        if (w_tx_bit_end) begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_tx_next = TX_START;
          end else begin
            w_tx_next = TX_IDLE;
          end
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_line  <= w_tx_line;
      if (w_pop) begin
        r_tx_shift <= w_head;
`ifdef UART_PARITY_EN
        r_tx_par   <= ^w_head;
`endif
      end
      if ((r_tx_state == TX_DATA) && w_tx_bit_end) begin
        r_tx_shift <= r_tx_shift >> 1;
        r_tx_bit   <= r_tx_bit + 4'd1;
      end
      if (w_tx_next != r_tx_state) begin
        r_tx_cnt <= '0;
        r_tx_bit <= '0;
      end else if (w_tick) begin
        r_tx_cnt <= r_tx_cnt + 4'd1;
      end
    end
  end

  // Registered pin drive keeps state-decode glitches off the line
  assign RsTx    = r_tx_line;
  assign tx_busy = (r_tx_state != TX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_buffered.sv
`default_nettype none
// Directed bench for uart_buffered at 16 clk per bit (DIV=1).
module tb_uart_buffered;

  logic       clk;
  logic       rst_n;
  logic       RsRx;
  logic       RsTx;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       echo_en;
  logic       echo_drop;
  logic [4:0] tx_count;
  logic       tx_busy;

  int n_cmp;
  int n_fail;

  int         n_valid;
  int         n_ferr;
  int         n_perr;
  int         n_vp;
  int         n_drop;
  logic [7:0] last_rx;

`ifdef UART_PARITY_EN
  logic par_flip;
  localparam int EXP_PERR = 1;
`else
  localparam int EXP_PERR = 0;
`endif

  uart_buffered #(
    .CLK_HZ    (1_600_000),
    .BAUD      (100_000),
    .DATA_W    (8),
    .FIFO_DEPTH(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RsRx         (RsRx),
    .RsTx         (RsTx),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .echo_en      (echo_en),
    .echo_drop    (echo_drop),
    .tx_count     (tx_count),
    .tx_busy      (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_valid = 0; n_ferr = 0; n_perr = 0; n_vp = 0; n_drop = 0; last_rx = 8'h00;
  end

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_valid = n_valid + 1;
      last_rx = rx_data;
    end
    if (rx_frame_err === 1'b1) n_ferr = n_ferr + 1;
    if (rx_parity_err === 1'b1) n_perr = n_perr + 1;
    if (rx_valid === 1'b1 && rx_parity_err === 1'b1) n_vp = n_vp + 1;
    if (echo_drop === 1'b1) n_drop = n_drop + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic stop);
    @(negedge clk);
    RsRx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RsRx = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    RsRx = (^d) ^ par_flip;
    repeat (16) @(negedge clk);
`endif
    RsRx = stop;
    repeat (16) @(negedge clk);
    RsRx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Returns start-bit tail (15 clk after the falling edge), data and stop.
  task automatic capture_tx(output logic [7:0] d, output logic st,
                            output logic tail, output logic ok);
    int w;
    d = 8'h00; st = 1'b0; tail = 1'b1; ok = 1'b0; w = 0;
    while (RsTx !== 1'b0 && w < 600) begin
      @(negedge clk);
      w++;
    end
    if (RsTx === 1'b0) begin
      ok = 1'b1;
      repeat (15) @(negedge clk);
      tail = RsTx;
      repeat (9) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        d[i] = RsTx;
        repeat (16) @(negedge clk);
      end
`ifdef UART_PARITY_EN
      check("tx_parity_bit", RsTx, ^d);
      repeat (16) @(negedge clk);
`endif
      st = RsTx;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       st, tail, ok;
    int         v0, f0, p0, dr0, w;

    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; RsRx = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; echo_en = 1'b0;
`ifdef UART_PARITY_EN
    par_flip = 1'b0;
`endif

    // Reset
    repeat (2) @(negedge clk);
    check("rst_rstx_during", RsTx, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rstx", RsTx, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_tx_count", tx_count, 5'd0);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_frame_err", rx_frame_err, 1'b0);
    check("rst_parity_err", rx_parity_err, 1'b0);
    check("rst_echo_drop", echo_drop, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);

    // TX 0x41
    tx_data = 8'h41; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    capture_tx(d, st, tail, ok);
    check("tx_frame_seen", ok, 1'b1);
    check("tx_start_16clk", tail, 1'b0);
    check("tx_data_41", d, 8'h41);
    check("tx_stop", st, 1'b1);
    check("tx_busy_in_stop", tx_busy, 1'b1);
    repeat (16) @(negedge clk);
    check("tx_busy_done", tx_busy, 1'b0);
    check("tx_line_idle", RsTx, 1'b1);
    check("tx_count_empty", tx_count, 5'd0);

    // RX 0xA5
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    drive_rx(8'hA5, 1'b1);
    check("rx_a5_valid_cnt", n_valid - v0, 1);
    check("rx_a5_pulse_data", last_rx, 8'hA5);
    check("rx_a5_data", rx_data, 8'hA5);
    check("rx_a5_ferr_cnt", n_ferr - f0, 0);
    check("rx_a5_perr_cnt", n_perr - p0, 0);
    check("rx_no_echo_count", tx_count, 5'd0);

    // RX with stop bit low
    v0 = n_valid; f0 = n_ferr;
    drive_rx(8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    check("rx_ferr_cnt", n_ferr - f0, 1);
    check("rx_ferr_no_valid", n_valid - v0, 0);
    check("rx_ferr_data_kept", rx_data, 8'hA5);

`ifdef UART_PARITY_EN
    // 0x07 carries odd parity, so a 0 parity bit is a mismatch
    v0 = n_valid; p0 = n_perr; f0 = n_vp;
    par_flip = 1'b1;
    drive_rx(8'h07, 1'b1);
    par_flip = 1'b0;
    check("par_valid_cnt", n_valid - v0, 1);
    check("par_err_cnt", n_perr - p0, 1);
    check("par_err_with_valid", n_vp - f0, 1);
    check("par_data_delivered", rx_data, 8'h07);
    repeat (10) @(negedge clk);
`endif

    // Fill the FIFO while a frame arrives; its echo must be dropped
    check("fill_tx_idle", tx_busy, 1'b0);
    echo_en = 1'b1;
    v0 = n_valid; dr0 = n_drop;
    fork
      drive_rx(8'h5A, 1'b1);
      begin
        for (int i = 0; i < 17; i++) begin
          tx_data = 8'(i + 1); tx_valid = 1'b1;
          @(negedge clk);
        end
        tx_valid = 1'b0;
        check("full_tx_ready", tx_ready, 1'b0);
        check("full_tx_count", tx_count, 5'd16);
      end
    join
    check("drop_rx_valid_cnt", n_valid - v0, 1);
    check("drop_rx_data", last_rx, 8'h5A);
    check("echo_drop_cnt", n_drop - dr0, 1);

    // Reset in the middle of a TX frame
    w = 0;
    while (RsTx !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("midtx_line_low", RsTx, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midtx_rst_line", RsTx, 1'b1);
    check("midtx_rst_count", tx_count, 5'd0);
    check("midtx_rst_busy", tx_busy, 1'b0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_line", RsTx, 1'b1);
    check("post_rst_busy", tx_busy, 1'b0);

    // Echo 0x30
    v0 = n_valid;
    fork
      drive_rx(8'h30, 1'b1);
      capture_tx(d, st, tail, ok);
    join
    check("echo_frame_seen", ok, 1'b1);
    check("echo_data_30", d, 8'h30);
    check("echo_stop", st, 1'b1);
    check("echo_rx_valid_cnt", n_valid - v0, 1);
    echo_en = 1'b0;
    repeat (40) @(negedge clk);
    check("echo_fifo_empty", tx_count, 5'd0);
    check("parity_err_total", n_perr, EXP_PERR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
